// File: rtl/frame_buffer_pkg.sv
// Shared types for the ping-pong frame buffer: reader state encoding and bank address helper.
// Combinational only; no latency and no backpressure of its own.
package frame_buffer_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT_RDY,
    RD_STREAM,
    RD_DRAIN
  } rd_state_e;

  // LRAM address is {bank, offset}; the bank bit sits directly above the aw offset bits.
  function automatic logic [31:0] bank_addr(input logic bank, input logic [30:0] offset,
                                            input int unsigned aw);
    return {1'b0, offset} | (32'(bank) << aw);
  endfunction

endpackage

// File: rtl/fb_rd_skid_fifo.sv
// Small generic FIFO used as the scanout skid buffer; head word is visible the cycle after push.
// Backpressure: head held stable until pop_rdy_i; producer must respect count_o (no overflow guard).
module fb_rd_skid_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_vld_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_rdy_i,
  output logic                       pop_vld_o,
  output logic [WIDTH-1:0]           pop_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop       = pop_rdy_i & (cnt_q != '0);
  assign pop_vld_o = (cnt_q != '0);
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

  always_comb begin
    wr_ptr_d = push_vld_i ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_vld_i && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push_vld_i && pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_vld_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Ping-pong LRAM frame buffer controller: writer fills the back bank, scanout streams the front bank.
// Write reaches port A one cycle after accept; reads return RD_LATENCY cycles after issue into a credit-guarded skid FIFO.
module frame_buffer_ctrl
  import frame_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BANK_AW     = 15,
  parameter int unsigned FRAME_WORDS = 16384,
  parameter int unsigned BYTE_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [BYTE_WIDTH-1:0] wr_ben_i,
  input  logic                  wr_frame_done_i,
  input  logic                  rd_start_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  input  logic                  lram_ready_i,
  output logic                  lram_wr_clk_en_o,
  output logic                  lram_wr_en_o,
  output logic [BANK_AW:0]      lram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] lram_wr_data_o,
  output logic [BYTE_WIDTH-1:0] lram_ben_o,
  output logic                  lram_rd_clk_en_o,
  output logic                  lram_rdout_clken_o,
  output logic [BANK_AW:0]      lram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] lram_rd_data_i,
  output logic                  front_bank_o,
  output logic                  swap_pending_o,
  output logic                  frame_overrun_o
);

  localparam int unsigned ADDR_W     = BANK_AW + 1;
  localparam int unsigned WCNT_W     = BANK_AW + 1;
  localparam int unsigned FIFO_DEPTH = RD_LATENCY + 1;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [WCNT_W-1:0]  FRAME_CNT = WCNT_W'(FRAME_WORDS);
  localparam logic [BANK_AW-1:0] LAST_OFS  = BANK_AW'(FRAME_WORDS - 1);

  // Write side and bank state
  logic                  run_q;
  logic                  front_bank_q, front_bank_d;
  logic                  swap_pending_q, swap_pending_d;
  logic [WCNT_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [BYTE_WIDTH-1:0] wr_ben_q, wr_ben_d;
  logic                  wr_ready, wr_acc, swap;

  // Read side
  rd_state_e             state_q, state_d;
  logic [BANK_AW-1:0]    rd_addr_q, rd_addr_d;
  logic [BANK_AW-1:0]    out_cnt_q, out_cnt_d;
  logic [RD_LATENCY-1:0] infl_q, infl_d;
  logic                  overrun_q, overrun_d;
  logic [CNT_W-1:0]      in_flight, fifo_cnt;
  logic                  credit_ok, issue, fifo_vld, pop, last_pop;
  logic [DATA_WIDTH-1:0] fifo_dat;

  // run_q keeps wr_ready_o low through reset even when the LRAM already reports ready.
  assign wr_ready = run_q & lram_ready_i & ~swap_pending_q & (wr_cnt_q < FRAME_CNT);
  assign wr_acc   = wr_valid_i & wr_ready;
  assign swap     = rd_start_i & (state_q == RD_IDLE) & swap_pending_q;

  always_comb begin
    front_bank_d   = front_bank_q ^ swap;
    swap_pending_d = swap_pending_q;
    if (swap) begin
      swap_pending_d = 1'b0;
    end else if (wr_frame_done_i) begin
      swap_pending_d = 1'b1;
    end
    wr_cnt_d  = wr_cnt_q;
    if (swap) begin
      wr_cnt_d = '0;
    end else if (wr_acc) begin
      wr_cnt_d = wr_cnt_q + WCNT_W'(1);
    end
    wr_en_d   = wr_acc;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_ben_d  = wr_ben_q;
    if (wr_acc) begin
      wr_addr_d = ADDR_W'(bank_addr(~front_bank_q, 31'(wr_cnt_q[BANK_AW-1:0]), BANK_AW));
      wr_data_d = wr_data_i;
      wr_ben_d  = wr_ben_i;
    end
  end

  // Outstanding reads plus buffered words never exceed the FIFO depth.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      in_flight = in_flight + CNT_W'(infl_q[i]);
    end
  end

  assign credit_ok = (in_flight + fifo_cnt) < CNT_W'(FIFO_DEPTH);
  assign issue     = (state_q == RD_STREAM) & lram_ready_i & credit_ok;
  assign pop       = fifo_vld & rd_ready_i;
  assign last_pop  = pop & rd_last_o;

  always_comb begin
    infl_d    = '0;
    infl_d[0] = issue;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      infl_d[i] = infl_q[i-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    out_cnt_d = pop ? out_cnt_q + BANK_AW'(1) : out_cnt_q;
    overrun_d = rd_start_i & (state_q != RD_IDLE);
    case (state_q)
      RD_IDLE: begin
        if (rd_start_i) begin
          rd_addr_d = '0;
          out_cnt_d = '0;
          state_d   = lram_ready_i ? RD_STREAM : RD_WAIT_RDY;
        end
      end
      RD_WAIT_RDY: begin
        if (lram_ready_i) begin
          state_d = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (issue) begin
          if (rd_addr_q == LAST_OFS) begin
            state_d = RD_DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + BANK_AW'(1);
          end
        end
      end
      RD_DRAIN: begin
        if (last_pop) begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q          <= 1'b0;
      front_bank_q   <= 1'b0;
      swap_pending_q <= 1'b0;
      wr_cnt_q       <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_ben_q       <= '0;
      state_q        <= RD_IDLE;
      rd_addr_q      <= '0;
      out_cnt_q      <= '0;
      infl_q         <= '0;
      overrun_q      <= 1'b0;
    end else begin
      run_q          <= 1'b1;
      front_bank_q   <= front_bank_d;
      swap_pending_q <= swap_pending_d;
      wr_cnt_q       <= wr_cnt_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      wr_ben_q       <= wr_ben_d;
      state_q        <= state_d;
      rd_addr_q      <= rd_addr_d;
      out_cnt_q      <= out_cnt_d;
      infl_q         <= infl_d;
      overrun_q      <= overrun_d;
    end
  end

  fb_rd_skid_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_vld_i (infl_q[RD_LATENCY-1]),
    .push_dat_i (lram_rd_data_i),
    .pop_rdy_i  (rd_ready_i),
    .pop_vld_o  (fifo_vld),
    .pop_dat_o  (fifo_dat),
    .count_o    (fifo_cnt)
  );

  assign wr_ready_o         = wr_ready;
  assign rd_valid_o         = fifo_vld;
  assign rd_data_o          = fifo_dat;
  assign rd_last_o          = fifo_vld & (out_cnt_q == LAST_OFS);
  assign lram_wr_clk_en_o   = wr_en_q;
  assign lram_wr_en_o       = wr_en_q;
  assign lram_wr_addr_o     = wr_addr_q;
  assign lram_wr_data_o     = wr_data_q;
  assign lram_ben_o         = wr_ben_q;
  assign lram_rd_clk_en_o   = issue;
  assign lram_rdout_clken_o = issue;
  assign lram_rd_addr_o     = issue ? ADDR_W'(bank_addr(front_bank_q, 31'(rd_addr_q), BANK_AW)) : '0;
  assign front_bank_o       = front_bank_q;
  assign swap_pending_o     = swap_pending_q;
  assign frame_overrun_o    = overrun_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Scoreboard bench for frame_buffer_ctrl with FRAME_WORDS=8, RD_LATENCY=2 and a behavioural LRAM.
// Stimulus pushes expected scanout words; a negedge monitor pops and compares them.
module tb_frame_buffer_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 15;
  localparam int unsigned FW = 8;
  localparam int unsigned BW = 4;
  localparam int unsigned RL = 2;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic [DW-1:0] wr_data_i = '0;
  logic [BW-1:0] wr_ben_i = '0;
  logic          wr_frame_done_i = 1'b0;
  logic          rd_start_i = 1'b0;
  logic          rd_valid_o;
  logic          rd_ready_i = 1'b0;
  logic [DW-1:0] rd_data_o;
  logic          rd_last_o;
  logic          lram_ready_i = 1'b0;
  logic          lram_wr_clk_en_o, lram_wr_en_o;
  logic [AW:0]   lram_wr_addr_o;
  logic [DW-1:0] lram_wr_data_o;
  logic [BW-1:0] lram_ben_o;
  logic          lram_rd_clk_en_o, lram_rdout_clken_o;
  logic [AW:0]   lram_rd_addr_o;
  logic [DW-1:0] lram_rd_data_i;
  logic          front_bank_o, swap_pending_o, frame_overrun_o;

  always #5 clk_i = ~clk_i;

  frame_buffer_ctrl #(
    .DATA_WIDTH (DW), .BANK_AW (AW), .FRAME_WORDS (FW), .BYTE_WIDTH (BW), .RD_LATENCY (RL)
  ) dut (
    .clk_i (clk_i), .rst_n_i (rst_n_i),
    .wr_valid_i (wr_valid_i), .wr_ready_o (wr_ready_o), .wr_data_i (wr_data_i), .wr_ben_i (wr_ben_i),
    .wr_frame_done_i (wr_frame_done_i), .rd_start_i (rd_start_i),
    .rd_valid_o (rd_valid_o), .rd_ready_i (rd_ready_i), .rd_data_o (rd_data_o), .rd_last_o (rd_last_o),
    .lram_ready_i (lram_ready_i), .lram_wr_clk_en_o (lram_wr_clk_en_o), .lram_wr_en_o (lram_wr_en_o),
    .lram_wr_addr_o (lram_wr_addr_o), .lram_wr_data_o (lram_wr_data_o), .lram_ben_o (lram_ben_o),
    .lram_rd_clk_en_o (lram_rd_clk_en_o), .lram_rdout_clken_o (lram_rdout_clken_o),
    .lram_rd_addr_o (lram_rd_addr_o), .lram_rd_data_i (lram_rd_data_i),
    .front_bank_o (front_bank_o), .swap_pending_o (swap_pending_o), .frame_overrun_o (frame_overrun_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // LRAM model: unwritten words read back as 0xBAD00000 | address; 2-cycle read pipeline.
  logic [DW-1:0] mem [1 << (AW + 1)];
  bit            mem_set [1 << (AW + 1)];
  logic [DW-1:0] rd_p0 = '0, rd_p1 = '0;

  function automatic logic [DW-1:0] rd_word(input logic [AW:0] a);
    return mem_set[a] ? mem[a] : (32'hBAD0_0000 | 32'(a));
  endfunction

  always @(posedge clk_i) begin : lram_model
    logic [DW-1:0] w;
    if (lram_wr_en_o && lram_wr_clk_en_o) begin
      w = rd_word(lram_wr_addr_o);
      for (int b = 0; b < int'(BW); b++) begin
        if (lram_ben_o[b]) w[8*b +: 8] = lram_wr_data_o[8*b +: 8];
      end
      mem[lram_wr_addr_o]     <= w;
      mem_set[lram_wr_addr_o] <= 1'b1;
    end
    rd_p0 <= lram_rd_clk_en_o ? rd_word(lram_rd_addr_o) : '0;
    rd_p1 <= rd_p0;
  end
  assign lram_rd_data_i = rd_p1;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          last;
  } exp_t;
  exp_t exp_q[$];
  int   popped = 0;
  int   rdy_mode = 0;

  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      1:       rd_ready_i = ~rd_ready_i;
      2:       rd_ready_i = ($urandom_range(0, 3) != 0);
      default: rd_ready_i = 1'b1;
    endcase
  end

  // Scanout monitor: order, last flag, and hold-stable under backpressure.
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_dat = '0;
  always @(negedge clk_i) begin : rd_monitor
    exp_t e;
    if (!rst_n_i) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) check("rd_hold_stable", rd_valid_o ? rd_data_o : ~stall_dat, stall_dat);
      if (rd_valid_o && rd_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected_word: got 0x%08h expected no word", rd_data_o);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data_o, e.dat);
          check("rd_last", 32'(rd_last_o), 32'(e.last));
          popped++;
        end
      end
      stall_q   = rd_valid_o && !rd_ready_i;
      stall_dat = rd_data_o;
    end
  end

  always @(negedge clk_i) begin
    if (rst_n_i && lram_wr_en_o) check("wr_addr_in_frame", 32'(lram_wr_addr_o[AW-1:0] < AW'(FW)), 32'd1);
  end

  task automatic write_word(input logic [DW-1:0] d, input logic [BW-1:0] ben);
    int n = 0;
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    wr_ben_i   = ben;
    while (!wr_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n == 50) check("wr_ready_timeout", 32'(wr_ready_o), 32'd1);
    @(negedge clk_i);
    wr_valid_i = 1'b0;
  endtask

  // Expected frame: word i = base + i, except word 3 which is given explicitly.
  task automatic push_exp(input logic [DW-1:0] base, input logic [DW-1:0] w3);
    for (int i = 0; i < int'(FW); i++) begin
      exp_q.push_back('{dat: (i == 3) ? w3 : base + DW'(i), last: (i == int'(FW) - 1)});
    end
  endtask

  task automatic pulse_done();
    wr_frame_done_i = 1'b1;
    @(negedge clk_i);
    wr_frame_done_i = 1'b0;
  endtask

  task automatic pulse_start();
    rd_start_i = 1'b1;
    @(negedge clk_i);
    rd_start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    if (n == 400) begin
      check("scanout_timeout_words_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk_i);
  endtask

  function automatic logic [31:0] flag_vec();
    return {22'b0, front_bank_o, swap_pending_o, frame_overrun_o, rd_valid_o, rd_last_o,
            wr_ready_o, lram_wr_en_o, lram_wr_clk_en_o, lram_rd_clk_en_o, lram_rdout_clken_o};
  endfunction

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_flags", flag_vec(), 32'd0);
    check("rst_addrs", {lram_wr_addr_o, lram_rd_addr_o}, 32'd0);
    check("rst_rd_data", rd_data_o, 32'd0);
    rst_n_i = 1'b1;
    lram_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("wr_ready_after_reset", 32'(wr_ready_o), 32'd1);

    // Frame A into bank 1, swap, scan out.
    for (int i = 0; i < int'(FW); i++) write_word(32'h10 + 32'(i), 4'hF);
    pulse_done();
    check("t1_swap_pending_set", 32'(swap_pending_o), 32'd1);
    check("t1_wr_ready_while_pending", 32'(wr_ready_o), 32'd0);
    push_exp(32'h10, 32'h13);
    pulse_start();
    check("t1_front_bank", 32'(front_bank_o), 32'd1);
    check("t1_swap_pending_clr", 32'(swap_pending_o), 32'd0);
    wait_idle();

    // Frame B into bank 0 with a partial byte enable; toggled ready and an LRAM-ready dropout.
    for (int i = 0; i < int'(FW); i++) write_word(32'h20 + 32'(i), (i == 3) ? 4'b0011 : 4'hF);
    pulse_done();
    rdy_mode = 1;
    push_exp(32'h20, 32'hBAD0_0023);
    pulse_start();
    check("t2_front_bank", 32'(front_bank_o), 32'd0);
    repeat (6) @(negedge clk_i);
    lram_ready_i = 1'b0;
    repeat (4) @(negedge clk_i);
    lram_ready_i = 1'b1;
    wait_idle();
    rdy_mode = 0;

    // Frame C into bank 1, then a ninth word must stall.
    for (int i = 0; i < int'(FW); i++) write_word(32'h30 + 32'(i), 4'hF);
    wr_valid_i = 1'b1;
    wr_data_i  = 32'h38;
    wr_ben_i   = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("t3_wr_ready_full", 32'(wr_ready_o), 32'd0);
    end
    wr_valid_i = 1'b0;
    @(negedge clk_i);
    check("t3_ninth_word_absent", rd_word(16'h8008), 32'hBAD0_8008);

    // Swap to C, then rd_start mid-frame is an overrun and must not swap.
    pulse_done();
    rdy_mode = 2;
    popped = 0;
    push_exp(32'h30, 32'h33);
    pulse_start();
    check("t4_front_bank", 32'(front_bank_o), 32'd1);
    for (int n = 0; n < 200 && popped < 3; n++) @(negedge clk_i);
    pulse_done();
    pulse_start();
    check("t4_overrun_pulse", 32'(frame_overrun_o), 32'd1);
    @(negedge clk_i);
    check("t4_overrun_one_cycle", 32'(frame_overrun_o), 32'd0);
    wait_idle();
    rdy_mode = 0;
    check("t4_front_unchanged", 32'(front_bank_o), 32'd1);
    check("t4_still_pending", 32'(swap_pending_o), 32'd1);

    // Pending swap applies at the next idle start: back to bank 0 (frame B).
    push_exp(32'h20, 32'hBAD0_0023);
    pulse_start();
    check("t4b_front_bank", 32'(front_bank_o), 32'd0);
    wait_idle();

    // Same-cycle done + start: redisplay, swap only on the following start.
    push_exp(32'h20, 32'hBAD0_0023);
    wr_frame_done_i = 1'b1;
    rd_start_i = 1'b1;
    @(negedge clk_i);
    wr_frame_done_i = 1'b0;
    rd_start_i = 1'b0;
    check("t5_no_swap_front", 32'(front_bank_o), 32'd0);
    check("t5_pending_set", 32'(swap_pending_o), 32'd1);
    wait_idle();
    rdy_mode = 1;
    push_exp(32'h30, 32'h33);
    pulse_start();
    check("t5_swap_front", 32'(front_bank_o), 32'd1);
    check("t5_pending_clr", 32'(swap_pending_o), 32'd0);
    wait_idle();
    rdy_mode = 0;

    // Reset in the middle of a streaming frame.
    push_exp(32'h30, 32'h33);
    pulse_start();
    repeat (4) @(negedge clk_i);
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    exp_q.delete();
    #1;
    check("t6_flags_async", flag_vec(), 32'd0);
    @(negedge clk_i);
    check("t6_flags_held", flag_vec(), 32'd0);
    check("t6_rd_data", rd_data_o, 32'd0);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("t6_front_after_reset", 32'(front_bank_o), 32'd0);
    push_exp(32'h20, 32'hBAD0_0023);
    pulse_start();
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
